mem_stage_lat: RTL and testbench

Next-generation MEM pipeline stage for the 5-stage MIPS CPU. It holds the EX/MEM pipeline register and resolves branch/jump (PCSrcM and target to IF). It embeds a data memory with a parametrised access latency and depth, and supports byte, halfword and word loads and stores. While a memory access is in flight, the stage asserts StallM so IF/ID/EX hold.

---
 rtl/mem_stage_lat_if.sv | 46 ++++
 rtl/mem_stage_lat.sv | 155 +++++++++++++++
 tb/tb_mem_stage_lat.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lat_if.sv
// EX->MEM handshake/bus bundle for the MEM stage: EX-side fields in, MEM-side results out.
// Latency: none, this is wiring only.
// Backpressure: StallM travels back to the EX side on this bundle.
interface mem_stage_lat_if;
  // EX-side fields captured by the stage
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic        ZeroE;
  logic [1:0]  SizeE;
  logic        UnsignedE;
  logic [5:0]  ALUopE;
  logic [31:0] WriteData_in;
  logic [31:0] PCPlus4_in;
  logic [31:0] PCBranch_in;
  logic [31:0] PCJump_in;
  logic [31:0] ALUOut_in;
  logic [4:0]  wb_addr_in;
  // MEM-side results
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [5:0]  ALUopM;
  logic [31:0] PCPlus4_out;
  logic [31:0] ALUOut_out;
  logic [31:0] ReadData_out;
  logic [4:0]  wb_addr_out;
  logic        PCSrcM;
  logic [31:0] PC_next_jumpOrBranch;
  logic        StallM;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ZeroE, SizeE, UnsignedE,
           ALUopE, WriteData_in, PCPlus4_in, PCBranch_in, PCJump_in, ALUOut_in, wb_addr_in,
    input  RegWriteM, MemtoRegM, ALUopM, PCPlus4_out, ALUOut_out, ReadData_out,
           wb_addr_out, PCSrcM, PC_next_jumpOrBranch, StallM
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ZeroE, SizeE, UnsignedE,
           ALUopE, WriteData_in, PCPlus4_in, PCBranch_in, PCJump_in, ALUOut_in, wb_addr_in,
    output RegWriteM, MemtoRegM, ALUopM, PCPlus4_out, ALUOut_out, ReadData_out,
           wb_addr_out, PCSrcM, PC_next_jumpOrBranch, StallM
  );
endinterface

// File: rtl/mem_stage_lat.sv
// MEM stage: EX/MEM register, branch/jump resolve, embedded data memory with byte/half/word access.
// Latency: non-memory ops 1 cycle; loads/stores occupy 1+MEM_LATENCY cycles.
// Backpressure: StallM is high while a memory op is in flight; the register holds and upstream must hold.
module mem_stage_lat #(
  parameter int DEPTH          = 512,
  parameter int MEM_LATENCY    = 2,
  parameter int ENABLE_SUBWORD = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  mem_stage_lat_if.slave bus
);
  localparam int         ADDR_W = $clog2(DEPTH);
  localparam logic [3:0] LAT    = 4'(MEM_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  aluop;
    logic [31:0] wdata;
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;
    logic [31:0] alu_out;
    logic [4:0]  wb_addr;
  } ex_t;

  ex_t         ex_q, ex_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              stall;
  logic [1:0]        eff_size;
  logic              eff_uns;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_fmt;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic              we;

  assign stall    = (state_q == BUSY);
  assign idx      = ex_q.alu_out[ADDR_W+1:2];
  assign lane     = ex_q.alu_out[1:0];
  assign eff_size = (ENABLE_SUBWORD != 0) ? ex_q.size : 2'b00;
  assign eff_uns  = (ENABLE_SUBWORD != 0) ? ex_q.uns  : 1'b0;
  assign we       = ex_q.mem_write & ~stall;

  // Next-state: capture EX fields when idle, count down the access latency when busy
  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = IDLE;
    end else begin
      ex_d.reg_write = bus.RegWriteE;
      ex_d.memto_reg = bus.MemtoRegE;
      ex_d.mem_write = bus.MemWriteE;
      ex_d.branch    = bus.BranchE;
      ex_d.jump      = bus.JumpE;
      ex_d.zero      = bus.ZeroE;
      ex_d.size      = bus.SizeE;
      ex_d.uns       = bus.UnsignedE;
      ex_d.aluop     = bus.ALUopE;
      ex_d.wdata     = bus.WriteData_in;
      ex_d.pc_plus4  = bus.PCPlus4_in;
      ex_d.pc_branch = bus.PCBranch_in;
      ex_d.pc_jump   = bus.PCJump_in;
      ex_d.alu_out   = bus.ALUOut_in;
      ex_d.wb_addr   = bus.wb_addr_in;
      if ((bus.MemtoRegE | bus.MemWriteE) && (MEM_LATENCY > 0)) begin
        state_d = BUSY;
        cnt_d   = LAT;
      end
    end
  end

  // Pipeline register and IDLE/BUSY FSM; reset aborts any op in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load path: asynchronous word read, lane select and sign/zero extension
  always_comb begin
    rd_word = mem[idx];
    rd_byte = rd_word[8*lane +: 8];
    rd_half = ex_q.alu_out[1] ? rd_word[31:16] : rd_word[15:0];
    case (eff_size)
      2'b01:   rd_fmt = eff_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      2'b10:   rd_fmt = eff_uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      default: rd_fmt = rd_word;
    endcase
  end

  // Store path: byte enables per size/lane, low byte/half replicated across lanes
  always_comb begin
    case (eff_size)
      2'b01: begin
        be   = ex_q.alu_out[1] ? 4'b1100 : 4'b0011;
        wrep = {2{ex_q.wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b0001 << lane;
        wrep = {4{ex_q.wdata[7:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = ex_q.wdata;
      end
    endcase
  end

  // Store commits on the edge that ends the op's final (non-stalled) cycle
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Load data is gated by the load flag so idle/reset output stays zero
  assign bus.ReadData_out         = ex_q.memto_reg ? rd_fmt : 32'b0;
  assign bus.RegWriteM            = ex_q.reg_write & ~stall;
  assign bus.MemtoRegM            = ex_q.memto_reg;
  assign bus.ALUopM               = ex_q.aluop;
  assign bus.PCPlus4_out          = ex_q.pc_plus4;
  assign bus.ALUOut_out           = ex_q.alu_out;
  assign bus.wb_addr_out          = ex_q.wb_addr;
  assign bus.PCSrcM               = (ex_q.branch & ex_q.zero) | ex_q.jump;
  assign bus.PC_next_jumpOrBranch = ex_q.jump ? ex_q.pc_jump : ex_q.pc_branch;
  assign bus.StallM               = stall;
endmodule

// File: tb/tb_mem_stage_lat.sv
module tb_mem_stage_lat;
  logic CLK;
  logic RST_N;
  int   n_vec;
  int   n_err;
  int   stall0_cnt;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        br;
    logic        jmp;
    logic        zero;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] pcb;
    logic [31:0] pcj;
    logic [31:0] alu;
    logic [4:0]  wb;
  } op_t;

  mem_stage_lat_if bus ();
  mem_stage_lat_if bus0 ();

  mem_stage_lat #(.DEPTH(512), .MEM_LATENCY(2), .ENABLE_SUBWORD(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  mem_stage_lat #(.DEPTH(512), .MEM_LATENCY(0), .ENABLE_SUBWORD(1)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0)
  );

  assign bus0.RegWriteE    = bus.RegWriteE;
  assign bus0.MemtoRegE    = bus.MemtoRegE;
  assign bus0.MemWriteE    = bus.MemWriteE;
  assign bus0.BranchE      = bus.BranchE;
  assign bus0.JumpE        = bus.JumpE;
  assign bus0.ZeroE        = bus.ZeroE;
  assign bus0.SizeE        = bus.SizeE;
  assign bus0.UnsignedE    = bus.UnsignedE;
  assign bus0.ALUopE       = bus.ALUopE;
  assign bus0.WriteData_in = bus.WriteData_in;
  assign bus0.PCPlus4_in   = bus.PCPlus4_in;
  assign bus0.PCBranch_in  = bus.PCBranch_in;
  assign bus0.PCJump_in    = bus.PCJump_in;
  assign bus0.ALUOut_in    = bus.ALUOut_in;
  assign bus0.wb_addr_in   = bus.wb_addr_in;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Zero-latency instance must never stall
  always @(negedge CLK) if (RST_N && bus0.StallM !== 1'b0) stall0_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  // Sub-word load vectors over word 0x80FF7F01 at 0x10
  logic [31:0] ld_addr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
  logic [1:0]  ld_size [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
  logic        ld_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ld_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000001};

  function automatic op_t nop_op();
    op_t o;
    o = '0;
    return o;
  endfunction

  function automatic op_t st_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    op_t o;
    o = '0; o.mw = 1'b1; o.alu = a; o.wdata = d; o.size = sz;
    return o;
  endfunction

  function automatic op_t ld_op(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    op_t o;
    o = '0; o.rw = 1'b1; o.m2r = 1'b1; o.alu = a; o.size = sz; o.uns = uns; o.wb = 5'd9;
    return o;
  endfunction

  function automatic op_t br_op(input logic br, input logic jmp, input logic zero,
                                input logic [31:0] pcb, input logic [31:0] pcj);
    op_t o;
    o = '0; o.br = br; o.jmp = jmp; o.zero = zero; o.pcb = pcb; o.pcj = pcj;
    return o;
  endfunction

  task automatic drive(input op_t o);
    bus.RegWriteE    = o.rw;
    bus.MemtoRegE    = o.m2r;
    bus.MemWriteE    = o.mw;
    bus.BranchE      = o.br;
    bus.JumpE        = o.jmp;
    bus.ZeroE        = o.zero;
    bus.SizeE        = o.size;
    bus.UnsignedE    = o.uns;
    bus.ALUopE       = o.rw ? 6'h23 : 6'h00;
    bus.WriteData_in = o.wdata;
    bus.PCPlus4_in   = (o == '0) ? 32'h0 : 32'h1004;
    bus.PCBranch_in  = o.pcb;
    bus.PCJump_in    = o.pcj;
    bus.ALUOut_in    = o.alu;
    bus.wb_addr_in   = o.wb;
  endtask

  // Present an op for exactly one capture edge, then return to nops
  task automatic issue(input op_t o);
    drive(o);
    @(posedge CLK); #1;
    drive(nop_op());
  endtask

  // Wait out the stall window; reports stall cycles and RegWriteM highs seen while stalled
  task automatic settle(output int stalls, output int rw_hi);
    stalls = 0;
    rw_hi  = 0;
    while (bus.StallM === 1'b1 && stalls < 20) begin
      if (bus.RegWriteM !== 1'b0) rw_hi++;
      @(posedge CLK); #1;
      stalls++;
    end
  endtask

  task automatic run_op(input op_t o, output int stalls, output int rw_hi);
    issue(o);
    settle(stalls, rw_hi);
  endtask

  task automatic test_reset();
    drive(nop_op());
    RST_N = 1'b0;
    #2;
    n_vec++; if (bus.StallM !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus.StallM); end
    n_vec++; if (bus.RegWriteM !== 1'b0 || bus.MemtoRegM !== 1'b0 || bus.PCSrcM !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b%b%b exp=000", bus.RegWriteM, bus.MemtoRegM, bus.PCSrcM); end
    n_vec++; if ({bus.ReadData_out, bus.ALUOut_out, bus.PCPlus4_out, bus.PC_next_jumpOrBranch} !== 128'h0) begin
      n_err++; $display("FAIL reset_buses got=%h exp=0", {bus.ReadData_out, bus.ALUOut_out, bus.PCPlus4_out, bus.PC_next_jumpOrBranch}); end
    n_vec++; if (bus.wb_addr_out !== 5'd0 || bus.ALUopM !== 6'd0) begin
      n_err++; $display("FAIL reset_fields got=%h/%h exp=0/0", bus.wb_addr_out, bus.ALUopM); end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      n_vec++; if ({bus.StallM, bus.RegWriteM, bus.PCSrcM, bus.ReadData_out} !== 35'h0) begin
        n_err++; $display("FAIL nop_stream cyc=%0d got=%b%b%b/%h exp=000/0", i, bus.StallM, bus.RegWriteM, bus.PCSrcM, bus.ReadData_out); end
    end
  endtask

  task automatic test_word_sw_lw();
    int s, r;
    run_op(st_op(32'h40, 32'hDEADBEEF, 2'b00), s, r);
    n_vec++; if (s != 2) begin n_err++; $display("FAIL sw_stall_cycles got=%0d exp=2", s); end
    n_vec++; if (r != 0) begin n_err++; $display("FAIL sw_regwrite got=%0d exp=0", r); end
    issue(ld_op(32'h40, 2'b00, 1'b0));
    n_vec++; if (bus.StallM !== 1'b1) begin n_err++; $display("FAIL lw_stall_first got=%b exp=1", bus.StallM); end
    n_vec++; if (bus0.ReadData_out !== 32'hDEADBEEF || bus0.RegWriteM !== 1'b1) begin
      n_err++; $display("FAIL lat0_lw got=%h/%b exp=deadbeef/1", bus0.ReadData_out, bus0.RegWriteM); end
    settle(s, r);
    n_vec++; if (s != 2) begin n_err++; $display("FAIL lw_stall_cycles got=%0d exp=2", s); end
    n_vec++; if (r != 0) begin n_err++; $display("FAIL lw_early_regwrite got=%0d exp=0", r); end
    n_vec++; if (bus.RegWriteM !== 1'b1) begin n_err++; $display("FAIL lw_regwrite got=%b exp=1", bus.RegWriteM); end
    n_vec++; if (bus.ReadData_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got=%h exp=deadbeef", bus.ReadData_out); end
    n_vec++; if (bus.wb_addr_out !== 5'd9 || bus.MemtoRegM !== 1'b1 || bus.ALUOut_out !== 32'h40) begin
      n_err++; $display("FAIL lw_fields got=%h/%b/%h exp=09/1/40", bus.wb_addr_out, bus.MemtoRegM, bus.ALUOut_out); end
    @(posedge CLK); #1;
    n_vec++; if (bus.RegWriteM !== 1'b0) begin n_err++; $display("FAIL lw_regwrite_pulse got=%b exp=0", bus.RegWriteM); end
  endtask

  task automatic test_subword_loads();
    int s, r;
    run_op(st_op(32'h10, 32'h80FF7F01, 2'b00), s, r);
    for (int i = 0; i < 4; i++) begin
      run_op(ld_op(ld_addr[i], ld_size[i], ld_uns[i]), s, r);
      n_vec++; if (bus.ReadData_out !== ld_exp[i]) begin
        n_err++; $display("FAIL subword_load[%0d] addr=%h got=%h exp=%h", i, ld_addr[i], bus.ReadData_out, ld_exp[i]); end
    end
  endtask

  task automatic test_store_lanes();
    int s, r;
    run_op(st_op(32'h20, 32'h0, 2'b00), s, r);
    run_op(st_op(32'h21, 32'h123456AB, 2'b10), s, r);
    run_op(ld_op(32'h20, 2'b00, 1'b0), s, r);
    n_vec++; if (bus.ReadData_out !== 32'h0000AB00) begin n_err++; $display("FAIL sb_lane got=%h exp=0000ab00", bus.ReadData_out); end
    run_op(ld_op(32'h820, 2'b00, 1'b0), s, r);
    n_vec++; if (bus.ReadData_out !== 32'h0000AB00) begin n_err++; $display("FAIL addr_wrap got=%h exp=0000ab00", bus.ReadData_out); end
    run_op(st_op(32'h22, 32'hFFFF1234, 2'b01), s, r);
    run_op(ld_op(32'h20, 2'b00, 1'b0), s, r);
    n_vec++; if (bus.ReadData_out !== 32'h1234AB00) begin n_err++; $display("FAIL sh_lane got=%h exp=1234ab00", bus.ReadData_out); end
    run_op(ld_op(32'h23, 2'b01, 1'b1), s, r);
    n_vec++; if (bus.ReadData_out !== 32'h00001234) begin n_err++; $display("FAIL lhu_odd got=%h exp=00001234", bus.ReadData_out); end
  endtask

  task automatic test_branch_jump();
    issue(br_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h400));
    n_vec++; if (bus.PCSrcM !== 1'b1 || bus.PC_next_jumpOrBranch !== 32'h100 || bus.StallM !== 1'b0) begin
      n_err++; $display("FAIL branch_taken got=%b/%h/%b exp=1/00000100/0", bus.PCSrcM, bus.PC_next_jumpOrBranch, bus.StallM); end
    issue(br_op(1'b0, 1'b1, 1'b0, 32'h200, 32'h400));
    n_vec++; if (bus.PCSrcM !== 1'b1 || bus.PC_next_jumpOrBranch !== 32'h400) begin
      n_err++; $display("FAIL jump got=%b/%h exp=1/00000400", bus.PCSrcM, bus.PC_next_jumpOrBranch); end
    issue(br_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h400));
    n_vec++; if (bus.PCSrcM !== 1'b0 || bus.PC_next_jumpOrBranch !== 32'h100) begin
      n_err++; $display("FAIL branch_not_taken got=%b/%h exp=0/00000100", bus.PCSrcM, bus.PC_next_jumpOrBranch); end
  endtask

  task automatic test_reset_busy();
    int s, r;
    run_op(st_op(32'h50, 32'h11111111, 2'b00), s, r);
    issue(st_op(32'h50, 32'h22222222, 2'b00));
    n_vec++; if (bus.StallM !== 1'b1) begin n_err++; $display("FAIL busy_before_reset got=%b exp=1", bus.StallM); end
    #1 RST_N = 1'b0;
    #1;
    n_vec++; if (bus.StallM !== 1'b0) begin n_err++; $display("FAIL reset_abort_stall got=%b exp=0", bus.StallM); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    run_op(ld_op(32'h50, 2'b00, 1'b0), s, r);
    n_vec++; if (bus.ReadData_out !== 32'h11111111) begin n_err++; $display("FAIL reset_abort_store got=%h exp=11111111", bus.ReadData_out); end
  endtask

  task automatic test_no_latency();
    n_vec++; if (stall0_cnt != 0) begin n_err++; $display("FAIL lat0_stall_cycles got=%0d exp=0", stall0_cnt); end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    stall0_cnt = 0;
    RST_N      = 1'b0;
    test_reset();
    test_word_sw_lw();
    test_subword_loads();
    test_store_lanes();
    test_branch_jump();
    test_reset_busy();
    test_no_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
